// File: rtl/sc1_uart_port.sv
// sc1_uart_port: 8N1 UART bridged onto the sc1_cpu port_out/port_in words
// through a toggle handshake, so polling firmware needs no extra strobes.
module sc1_uart_port #(
    parameter int CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] port_out,
    output logic [31:0] port_in,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_txd_q, tx_txd_d;
    logic        tx_tog_q, tx_tog_d;
    logic        tx_done;

    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q;
    logic        rx_done, rx_good, rx_ferr;

    logic        rx_vld_q, ovr_q, ferr_q, ack_q;
    logic [7:0]  rx_data_q;
    logic        rx_free, ack_chg, deliver;
    logic        unused_port_bits;

    assign unused_port_bits = ^port_out[29:8];
    assign tx_done = tx_cnt_q == DIV_LAST;
    assign rx_done = rx_cnt_q == DIV_LAST;
    // Compare against the live ack bit so a same-cycle ack frees the slot.
    assign rx_free = rx_vld_q == port_out[30];
    assign ack_chg = ack_q != port_out[30];
    assign deliver = rx_good && rx_free;

    assign uart_txd = tx_txd_q;
    assign port_in  = {tx_tog_q, rx_vld_q, ovr_q, ferr_q, tx_state_q != IDLE, 19'd0, rx_data_q};

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_txd_d   = tx_txd_q;
        tx_tog_d   = tx_tog_q;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (port_out[31] != tx_tog_q) begin
                    tx_state_d = START;
                    tx_tog_d   = ~tx_tog_q;
                    tx_shift_d = port_out[7:0];
                    tx_txd_d   = 1'b0;
                end
            end
            START: if (tx_done) begin
                tx_state_d = DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_txd_d   = tx_shift_q[0];
            end
            DATA: if (tx_done) begin
                tx_cnt_d   = '0;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_state_d = tx_bit_q == 3'd7 ? STOP : DATA;
                tx_txd_d   = tx_bit_q == 3'd7 ? 1'b1 : tx_shift_q[1];
            end
            STOP: if (tx_done) begin
                tx_state_d = IDLE;
                tx_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_txd_q   <= 1'b1;
            tx_tog_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_txd_q   <= tx_txd_d;
            tx_tog_q   <= tx_tog_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d   = '0;
                rx_state_d = rx_s2_q ? IDLE : START;
            end
            // Mid-start-bit sample rejects short glitches.
            START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: if (rx_done) begin
                rx_cnt_d   = '0;
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_state_d = rx_bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (rx_done) begin
                rx_state_d = IDLE;
                rx_good    = rx_s2_q;
                rx_ferr    = ~rx_s2_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_vld_q   <= 1'b0;
            rx_data_q  <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= uart_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_vld_q   <= rx_vld_q ^ deliver;
            rx_data_q  <= deliver ? rx_shift_q : rx_data_q;
            ovr_q      <= (rx_good && !rx_free) || (ovr_q && !ack_chg);
            ferr_q     <= rx_ferr || (ferr_q && !ack_chg);
            ack_q      <= port_out[30];
        end
    end
endmodule
